// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - VGA sync timing monitor with lock detection and pixel coordinate output
//
// Purpose:
//   Measures incoming VGA hsync/vsync timing on pixel ticks (pix_ce). It produces
//   active-area pixel coordinates and registered colour, and reports the measured
//   line length and frame height. It flags timing mismatches and declares lock
//   after LOCK_FRAMES consecutive clean frames.
//
// Ports:
//   sys_clk     in   1   system clock
//   rst         in   1   asynchronous active-high reset
//   pix_ce      in   1   pixel-tick enable, one sys_clk wide
//   vga_h       in   1   horizontal sync, active-low
//   vga_v       in   1   vertical sync, active-low
//   RGB         in  12   pixel colour {R,G,B}
//   pix_x       out 10   active-area x coordinate, 0 outside active area
//   pix_y       out 10   active-area y coordinate, 0 outside active area
//   active      out  1   sampled pixel lies in the active area
//   rgb_out     out 12   registered colour, 0 when not active
//   frame_start out  1   one-sys_clk pulse on each vsync falling edge
//   locked      out  1   timing matches parameters
//   h_meas      out 10   last measured line length
//   v_meas      out 10   last measured frame height
//   timing_err  out  1   one-sys_clk pulse on a length mismatch or sync loss
//   frame_sum   out 24   active-pixel checksum of the last frame
//
// Optional feature macro: VGA_MON_FRAME_SUM_EN enables the frame checksum
// accumulator; without it frame_sum is tied to 0.

module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_LEN   = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_LEN   = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        vga_h,
    input  logic        vga_v,
    input  logic [11:0] RGB,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        active,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic [9:0]  h_meas,
    output logic [9:0]  v_meas,
    output logic        timing_err,
    output logic [23:0] frame_sum
);

    localparam logic [9:0] CNT_MAX       = 10'd1023;
    localparam logic [9:0] CNT_PRE_MAX   = 10'd1022;
    localparam logic [9:0] LP_H_TOTAL    = 10'(H_TOTAL);
    localparam logic [9:0] LP_V_TOTAL    = 10'(V_TOTAL);
    localparam logic [9:0] LP_H_ACT_BEG  = 10'(H_ACT_START);
    localparam logic [9:0] LP_H_ACT_END  = 10'(H_ACT_START + H_ACT_LEN - 1);
    localparam logic [9:0] LP_V_ACT_BEG  = 10'(V_ACT_START);
    localparam logic [9:0] LP_V_ACT_END  = 10'(V_ACT_START + V_ACT_LEN - 1);
    localparam int         GOOD_W        = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] LP_LOCK = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Synchronizers (run every sys_clk) and edge-detect history (pix_ce only)
    logic [1:0]  r_h_sync;
    logic [1:0]  r_v_sync;
    logic [11:0] r_rgb_s1;
    logic [11:0] r_rgb_s2;
    logic        r_h_prev;
    logic        r_v_prev;

    // Counters, measurement validity and outputs
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_h_seen;
    logic        r_v_seen;
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic        r_active;
    logic [11:0] r_rgb_out;
    logic        r_frame_start;
    logic        r_timing_err;
    logic [9:0]  r_h_meas;
    logic [9:0]  r_v_meas;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GOOD_W-1:0] r_good;
    logic [GOOD_W-1:0] w_good_nxt;
    logic [GOOD_W-1:0] w_good_inc;

    logic        w_h_s;
    logic        w_v_s;
    logic        w_h_fall;
    logic        w_v_fall;
    logic [9:0]  w_h_inc;
    logic [9:0]  w_v_inc;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    logic        w_active;
    logic        w_h_err;
    logic        w_v_err;
    logic        w_sync_loss;
    logic        w_mismatch;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_h_sync <= 2'b11;
            r_v_sync <= 2'b11;
            r_rgb_s1 <= 12'd0;
            r_rgb_s2 <= 12'd0;
        end else begin
            r_h_sync <= {r_h_sync[0], vga_h};
            r_v_sync <= {r_v_sync[0], vga_v};
            r_rgb_s1 <= RGB;
            r_rgb_s2 <= r_rgb_s1;
        end
    end

    // The counter values after this tick are the coordinates of the pixel
    // sampled on this tick, so the hsync falling tick is pixel 0 of its line.
    always_comb begin
        w_h_s       = r_h_sync[1];
        w_v_s       = r_v_sync[1];
        w_h_fall    = r_h_prev & ~w_h_s;
        w_v_fall    = r_v_prev & ~w_v_s;
        w_h_inc     = (r_h_cnt == CNT_MAX) ? CNT_MAX : r_h_cnt + 10'd1;
        w_v_inc     = (r_v_cnt == CNT_MAX) ? CNT_MAX : r_v_cnt + 10'd1;
        w_h_next    = w_h_fall ? 10'd0 : w_h_inc;
        w_v_next    = w_v_fall ? 10'd0 : (w_h_fall ? w_v_inc : r_v_cnt);
        w_active    = (w_h_next >= LP_H_ACT_BEG) && (w_h_next <= LP_H_ACT_END) &&
                      (w_v_next >= LP_V_ACT_BEG) && (w_v_next <= LP_V_ACT_END);
        // A length is only checked once a previous edge has opened the
        // measurement window; counts started by reset or sync loss are partial.
        w_h_err     = w_h_fall & r_h_seen & (w_h_inc != LP_H_TOTAL);
        w_v_err     = w_v_fall & r_v_seen & (w_v_inc != LP_V_TOTAL);
        // Fires only on the tick that takes h_cnt into saturation.
        w_sync_loss = ~w_h_fall & (r_h_cnt == CNT_PRE_MAX);
        w_mismatch  = w_h_err | w_v_err | w_sync_loss;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_h_prev  <= 1'b1;
            r_v_prev  <= 1'b1;
            r_h_cnt   <= 10'd0;
            r_v_cnt   <= 10'd0;
            r_h_seen  <= 1'b0;
            r_v_seen  <= 1'b0;
            r_h_meas  <= 10'd0;
            r_v_meas  <= 10'd0;
            r_pix_x   <= 10'd0;
            r_pix_y   <= 10'd0;
            r_active  <= 1'b0;
            r_rgb_out <= 12'd0;
        end else if (pix_ce) begin
            r_h_prev <= w_h_s;
            r_v_prev <= w_v_s;
            r_h_cnt  <= w_h_next;
            r_v_cnt  <= w_v_next;
            if (w_sync_loss) begin
                r_h_seen <= 1'b0;
                r_v_seen <= 1'b0;
            end else begin
                if (w_h_fall) begin
                    r_h_seen <= 1'b1;
                end
                if (w_v_fall) begin
                    r_v_seen <= 1'b1;
                end
            end
            if (w_h_fall) begin
                r_h_meas <= w_h_inc;
            end
            if (w_v_fall) begin
                r_v_meas <= w_v_inc;
            end
            r_active  <= w_active;
            r_pix_x   <= w_active ? (w_h_next - LP_H_ACT_BEG) : 10'd0;
            r_pix_y   <= w_active ? (w_v_next - LP_V_ACT_BEG) : 10'd0;
            r_rgb_out <= w_active ? r_rgb_s2 : 12'd0;
        end
    end

    // Pulses are rebuilt every sys_clk so they last exactly one clock.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
        end else begin
            r_frame_start <= pix_ce & w_v_fall;
            r_timing_err  <= pix_ce & w_mismatch;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= SEARCH;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_good_inc  = r_good + GOOD_W'(1);
        if (pix_ce) begin
            case (r_state)
                SEARCH: begin
                    // The frame ending here started before we were watching,
                    // so it only opens tracking and never counts as good.
                    if (!w_mismatch && w_v_fall) begin
                        w_state_nxt = TRACK;
                        w_good_nxt  = '0;
                    end
                end
                TRACK: begin
                    if (w_mismatch) begin
                        w_state_nxt = SEARCH;
                        w_good_nxt  = '0;
                    end else if (w_v_fall) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == LP_LOCK) begin
                            w_state_nxt = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (w_mismatch) begin
                        w_state_nxt = SEARCH;
                        w_good_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

`ifdef VGA_MON_FRAME_SUM_EN
    logic [23:0] r_acc;
    logic [23:0] r_frame_sum;

    // The vsync tick's pixel belongs to the new frame, so it seeds the accumulator.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_acc       <= 24'd0;
            r_frame_sum <= 24'd0;
        end else if (pix_ce) begin
            if (w_v_fall) begin
                r_frame_sum <= r_acc;
                r_acc       <= w_active ? {12'd0, r_rgb_s2} : 24'd0;
            end else if (w_active) begin
                r_acc <= r_acc + {12'd0, r_rgb_s2};
            end
        end
    end

    assign frame_sum = r_frame_sum;
`else
    assign frame_sum = 24'd0;
`endif

    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign active      = r_active;
    assign rgb_out     = r_rgb_out;
    assign frame_start = r_frame_start;
    assign locked      = (r_state == LOCKED);
    assign h_meas      = r_h_meas;
    assign v_meas      = r_v_meas;
    assign timing_err  = r_timing_err;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb/tb_vga_timing_monitor.sv - directed self-checking bench for vga_timing_monitor

module tb_vga_timing_monitor;

    localparam int HT = 20;
    localparam int VT = 12;
    localparam int HS = 4;
    localparam int HL = 10;
    localparam int VS = 3;
    localparam int VL = 6;
    localparam int LF = 2;
`ifdef VGA_MON_FRAME_SUM_EN
    localparam int EXP_SUM = 86700;
`else
    localparam int EXP_SUM = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce = 1'b0;
    logic        vga_h = 1'b1;
    logic        vga_v = 1'b1;
    logic [11:0] RGB = 12'd0;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        active;
    logic [11:0] rgb_out;
    logic        frame_start;
    logic        locked;
    logic [9:0]  h_meas;
    logic [9:0]  v_meas;
    logic        timing_err;
    logic [23:0] frame_sum;

    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_err_pulses = 0;
    int          n_fs = 0;
    int          n_wide = 0;
    logic        last_err = 1'b0;
    logic [11:0] pre_rgb = 12'd0;

    always #5 sys_clk = ~sys_clk;

    vga_timing_monitor #(
        .H_TOTAL    (HT),
        .V_TOTAL    (VT),
        .H_ACT_START(HS),
        .H_ACT_LEN  (HL),
        .V_ACT_START(VS),
        .V_ACT_LEN  (VL),
        .LOCK_FRAMES(LF)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .pix_ce     (pix_ce),
        .vga_h      (vga_h),
        .vga_v      (vga_v),
        .RGB        (RGB),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .active     (active),
        .rgb_out    (rgb_out),
        .frame_start(frame_start),
        .locked     (locked),
        .h_meas     (h_meas),
        .v_meas     (v_meas),
        .timing_err (timing_err),
        .frame_sum  (frame_sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel tick: inputs change, pix_ce rides the third following edge.
    task automatic tick(input logic h, input logic v, input logic [11:0] rgb);
        @(negedge sys_clk);
        if (timing_err || frame_start) n_wide++;
        vga_h  = h;
        vga_v  = v;
        RGB    = rgb;
        pix_ce = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        pre_rgb = rgb_out;
        pix_ce  = 1'b1;
        @(negedge sys_clk);
        pix_ce   = 1'b0;
        last_err = timing_err;
        if (timing_err) n_err_pulses++;
        if (frame_start) n_fs++;
    endtask

    task automatic run_line(input int l, input int from, input int to);
        for (int i = from; i < to; i++) begin
            tick((i < 2) ? 1'b0 : 1'b1, (l < 2) ? 1'b0 : 1'b1, 12'h5A5);
        end
    endtask

    task automatic run_frame();
        for (int l = 0; l < VT; l++) run_line(l, 0, HT);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pix_x"}, 32'(pix_x), 0);
        check({tag, ".pix_y"}, 32'(pix_y), 0);
        check({tag, ".active"}, 32'(active), 0);
        check({tag, ".rgb_out"}, 32'(rgb_out), 0);
        check({tag, ".frame_start"}, 32'(frame_start), 0);
        check({tag, ".locked"}, 32'(locked), 0);
        check({tag, ".h_meas"}, 32'(h_meas), 0);
        check({tag, ".v_meas"}, 32'(v_meas), 0);
        check({tag, ".timing_err"}, 32'(timing_err), 0);
        check({tag, ".frame_sum"}, 32'(frame_sum), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Three clean frames: lock on the third vsync edge
        run_frame();
        check("fs_first", n_fs, 1);
        run_frame();
        check("locked_after_2_edges", 32'(locked), 0);
        run_frame();
        check("locked_after_3_edges", 32'(locked), 1);
        check("h_meas_clean", 32'(h_meas), 20);
        check("v_meas_clean", 32'(v_meas), 12);
        check("no_err_clean", n_err_pulses, 0);
        check("fs_count", n_fs, 3);
        check("frame_sum_clean", 32'(frame_sum), EXP_SUM);

        // Active-area boundaries and 3-clock latency in frame 4
        for (int l = 0; l < 3; l++) run_line(l, 0, HT);
        run_line(3, 0, HS);
        check("h3_inactive", 32'(active), 0);
        tick(1'b1, 1'b1, 12'hF00);
        check("first_px_pre_rgb", 32'(pre_rgb), 0);
        check("first_px_rgb", 32'(rgb_out), 'hF00);
        check("first_px_x", 32'(pix_x), 0);
        check("first_px_y", 32'(pix_y), 0);
        check("first_px_active", 32'(active), 1);
        run_line(3, HS + 1, HS + HL);
        check("last_px_x", 32'(pix_x), 9);
        check("last_px_rgb", 32'(rgb_out), 'h5A5);
        run_line(3, HS + HL, HS + HL + 1);
        check("past_end_active", 32'(active), 0);
        check("past_end_rgb", 32'(rgb_out), 0);
        check("past_end_x", 32'(pix_x), 0);
        run_line(3, HS + HL + 1, HT);
        for (int l = 4; l < 9; l++) run_line(l, 0, HT);
        run_line(9, 0, HS + 1);
        check("v_below_active", 32'(active), 0);
        run_line(9, HS + 1, HT);
        run_line(10, 0, HT);
        run_line(11, 0, HT);

        // One short line while locked
        for (int l = 0; l < 5; l++) run_line(l, 0, HT);
        run_line(5, 0, HT - 1);
        check("locked_before_short", 32'(locked), 1);
        run_line(6, 0, 1);
        check("short_err_pulse", 32'(last_err), 1);
        check("short_unlock", 32'(locked), 0);
        check("short_h_meas", 32'(h_meas), 19);
        check("short_err_count", n_err_pulses, 1);
        run_line(6, 1, HT);
        for (int l = 7; l < VT; l++) run_line(l, 0, HT);
        run_frame();
        run_frame();
        check("relock_pending", 32'(locked), 0);
        run_frame();
        check("relocked", 32'(locked), 1);
        check("relock_err_count", n_err_pulses, 1);

        // Sync loss: hsync stuck high
        for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 12'h5A5);
        check("loss_err_count", n_err_pulses, 2);
        check("loss_unlock", 32'(locked), 0);
        run_line(0, 0, 1);
        check("loss_h_meas_sat", 32'(h_meas), 1023);
        run_line(0, 1, HT);
        for (int l = 1; l < VT; l++) run_line(l, 0, HT);
        check("loss_recover_err_count", n_err_pulses, 2);
        run_frame();
        run_frame();
        check("loss_relocked", 32'(locked), 1);

        // Reset mid-line while locked
        for (int l = 0; l < 5; l++) run_line(l, 0, HT);
        run_line(5, 0, 8);
        check("pre_rst_active", 32'(active), 1);
        check("pre_rst_x", 32'(pix_x), 3);
        check("pre_rst_y", 32'(pix_y), 2);
        @(negedge sys_clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        run_frame();
        run_frame();
        check("post_rst_2_edges", 32'(locked), 0);
        run_frame();
        check("post_rst_3_edges", 32'(locked), 1);
        check("final_err_count", n_err_pulses, 2);
        check("pulse_width", n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
